result_frame_streamer: RTL and testbench

//   Receiving end of the threshold result-write interface (col/row/1-bit data/wren).

---
 rtl/result_frame_streamer.sv | 118 +++++++++++
 tb/tb_result_frame_streamer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_frame_streamer.sv
// Captures a 1-bit binarised frame from the threshold write port, then
// replays it in raster order as a valid/ready pixel stream once finished.
module result_frame_streamer #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [WIDTH_BITS-1:0]             iResultCol,
    input  logic [HEIGHT_BITS-1:0]            iResultRow,
    input  logic                              iResultData,
    input  logic                              iResultWren,
    input  logic                              iFinished,
    output logic [WIDTH_BITS-1:0]             oCol,
    output logic [HEIGHT_BITS-1:0]            oRow,
    output logic                              oData,
    output logic                              oValid,
    input  logic                              iReady,
    output logic                              oFirst,
    output logic                              oLast,
    output logic                              oDone,
    output logic [WIDTH_BITS+HEIGHT_BITS:0]   oWriteCount
);

    localparam int ADDR_BITS = WIDTH_BITS + HEIGHT_BITS;
    localparam int DEPTH     = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

    localparam logic [1:0] CAPTURE = 2'd0;
    localparam logic [1:0] READOUT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]           state;
    logic                 frameMem [DEPTH];
    logic                 armed;
    logic                 fetchLeft;
    logic [ADDR_BITS-1:0] fetchAddr;
    logic                 stageValid;
    logic [ADDR_BITS-1:0] stageAddr;
    logic                 stageData;
    logic                 advance;
    logic                 fetch;
    logic                 writeEn;

    // Output register and read stage move together; both stall on backpressure.
    assign advance = !oValid || iReady;
    assign fetch   = (state == READOUT) && armed && advance && fetchLeft;
    assign writeEn = (state == CAPTURE) && iResultWren;

    always_ff @(posedge clock) begin
        if (writeEn)
            frameMem[{iResultRow, iResultCol}] <= iResultData;
        if (fetch)
            stageData <= frameMem[fetchAddr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= CAPTURE;
            armed       <= 1'b0;
            fetchLeft   <= 1'b0;
            fetchAddr   <= '0;
            stageValid  <= 1'b0;
            stageAddr   <= '0;
            oCol        <= '0;
            oRow        <= '0;
            oData       <= 1'b0;
            oValid      <= 1'b0;
            oFirst      <= 1'b0;
            oLast       <= 1'b0;
            oDone       <= 1'b0;
            oWriteCount <= '0;
        end else begin
            unique case (state)
                CAPTURE: begin
                    if (iResultWren && oWriteCount != FULL_COUNT)
                        oWriteCount <= oWriteCount + 1'b1;
                    if (iFinished) begin
                        state     <= READOUT;
                        armed     <= 1'b0;
                        fetchLeft <= 1'b1;
                        fetchAddr <= '0;
                    end
                end
                READOUT: begin
                    // One idle cycle lets the final capture write settle first.
                    armed <= 1'b1;
                    if (advance) begin
                        oValid     <= stageValid;
                        oCol       <= stageAddr[WIDTH_BITS-1:0];
                        oRow       <= stageAddr[ADDR_BITS-1:WIDTH_BITS];
                        oData      <= stageValid && stageData;
                        oFirst     <= stageValid && (stageAddr == '0);
                        oLast      <= stageValid && (&stageAddr);
                        stageValid <= fetch;
                        if (fetch) begin
                            stageAddr <= fetchAddr;
                            fetchAddr <= fetchAddr + 1'b1;
                            if (&fetchAddr)
                                fetchLeft <= 1'b0;
                        end
                    end
                    if (oValid && iReady && oLast) begin
                        state <= DONE;
                        oDone <= 1'b1;
                    end
                end
                DONE: begin
                    oDone <= 1'b1;
                end
                default: begin
                    state <= CAPTURE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_frame_streamer.sv
// Randomised self-checking bench for result_frame_streamer on a small
// 16x8 frame, compared against a raster-order array model.
module tb_result_frame_streamer;

    localparam int WB = 4;
    localparam int HB = 3;
    localparam int W  = 2 ** WB;
    localparam int H  = 2 ** HB;
    localparam int N  = W * H;
    localparam int VW = WB + HB + 3;

    logic              clock;
    logic              reset;
    logic [WB-1:0]     iResultCol;
    logic [HB-1:0]     iResultRow;
    logic              iResultData;
    logic              iResultWren;
    logic              iFinished;
    logic [WB-1:0]     oCol;
    logic [HB-1:0]     oRow;
    logic              oData;
    logic              oValid;
    logic              iReady;
    logic              oFirst;
    logic              oLast;
    logic              oDone;
    logic [WB+HB:0]    oWriteCount;
    logic [VW-1:0]     obsVec;

    int checks   = 0;
    int failures = 0;
    bit model [N];
    int nWrites;

    result_frame_streamer #(
        .WIDTH_BITS (WB),
        .HEIGHT_BITS(HB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iResultCol (iResultCol),
        .iResultRow (iResultRow),
        .iResultData(iResultData),
        .iResultWren(iResultWren),
        .iFinished  (iFinished),
        .oCol       (oCol),
        .oRow       (oRow),
        .oData      (oData),
        .oValid     (oValid),
        .iReady     (iReady),
        .oFirst     (oFirst),
        .oLast      (oLast),
        .oDone      (oDone),
        .oWriteCount(oWriteCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign obsVec = {oCol, oRow, oData, oFirst, oLast};

    // Expected transfer number idx: raster position plus stored pixel.
    function automatic logic [VW-1:0] expVec(input int idx);
        logic [WB-1:0] c;
        logic [HB-1:0] r;
        logic          d;
        c = WB'(idx % W);
        r = HB'(idx / W);
        d = (idx < N) ? model[idx] : 1'b0;
        return {c, r, d, idx == 0, idx == N - 1};
    endfunction

    function automatic int expCount();
        return (nWrites > N) ? N : nWrites;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        iResultWren = 1'b0;
        iFinished   = 1'b0;
        iReady      = 1'b0;
        iResultCol  = '0;
        iResultRow  = '0;
        iResultData = 1'b0;
        @(negedge clock);
        reset   = 1'b0;
        nWrites = 0;
    endtask

    task automatic write_px(input int c, input int r, input bit d);
        @(negedge clock);
        iResultWren = 1'b1;
        iResultCol  = WB'(c);
        iResultRow  = HB'(r);
        iResultData = d;
        model[r * W + c] = d;
        nWrites++;
    endtask

    task automatic write_frame(input bit rnd, input bit skip53);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (!(skip53 && c == 5 && r == 3))
                    write_px(c, r, rnd ? bit'($urandom % 2) : bit'((c ^ r) & 1));
        @(negedge clock);
        iResultWren = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({oValid, oFirst, oLast, oDone, oData} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {oValid, oFirst, oLast, oDone, oData});
        end
        checks++;
        if ({oCol, oRow} !== '0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=0", {oCol, oRow});
        end
        checks++;
        if (oWriteCount !== '0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", oWriteCount);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        int lat;
        do_reset();
        write_frame(1'b0, 1'b0);
        checks++;
        if (oWriteCount !== (WB+HB+1)'(N)) begin
            failures++;
            $display("FAIL ff_count got=%0d exp=%0d", oWriteCount, N);
        end
        iReady    = 1'b1;
        iFinished = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            iFinished = 1'b0;
            if (oValid) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL ff_latency got=%0d exp=4", lat);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (!oValid || obsVec !== expVec(i)) begin
                failures++;
                $display("FAIL ff_px idx=%0d valid=%b got=%h exp=%h",
                         i, oValid, obsVec, expVec(i));
            end
            @(negedge clock);
        end
        checks++;
        if ({oDone, oValid} !== 2'b10) begin
            failures++;
            $display("FAIL ff_done got=%b exp=10", {oDone, oValid});
        end
    endtask

    task automatic test_backpressure();
        int       idx;
        bit       stalled;
        bit       r;
        logic [VW-1:0] held;
        do_reset();
        write_frame(1'b1, 1'b0);
        iReady    = 1'b0;
        iFinished = 1'b1;
        idx       = 0;
        stalled   = 1'b0;
        held      = '0;
        for (int cyc = 0; cyc < 8 * N && !oDone; cyc++) begin
            @(negedge clock);
            iFinished = 1'b0;
            if (stalled) begin
                checks++;
                if (!oValid || obsVec !== held) begin
                    failures++;
                    $display("FAIL bp_hold idx=%0d valid=%b got=%h exp=%h",
                             idx, oValid, obsVec, held);
                end
            end
            r = bit'($urandom % 2);
            iReady = r;
            if (oValid) begin
                if (r) begin
                    checks++;
                    if (obsVec !== expVec(idx)) begin
                        failures++;
                        $display("FAIL bp_px idx=%0d got=%h exp=%h",
                                 idx, obsVec, expVec(idx));
                    end
                    idx++;
                end
                stalled = !r;
                held    = obsVec;
            end
        end
        checks++;
        if (idx != N || !oDone) begin
            failures++;
            $display("FAIL bp_total got=%0d done=%b exp=%0d", idx, oDone, N);
        end
    endtask

    task automatic test_overwrite();
        int idx;
        do_reset();
        write_px(5, 3, 1'b1);
        write_px(5, 3, 1'b0);
        @(negedge clock);
        iResultWren = 1'b0;
        checks++;
        if (oWriteCount !== (WB+HB+1)'(2)) begin
            failures++;
            $display("FAIL ovw_count2 got=%0d exp=2", oWriteCount);
        end
        write_frame(1'b1, 1'b1);
        checks++;
        if (oWriteCount !== (WB+HB+1)'(expCount())) begin
            failures++;
            $display("FAIL ovw_sat got=%0d exp=%0d", oWriteCount, expCount());
        end
        iReady    = 1'b1;
        iFinished = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < N + 20 && !oDone; cyc++) begin
            @(negedge clock);
            iFinished = 1'b0;
            if (oValid) begin
                checks++;
                if (obsVec !== expVec(idx)) begin
                    failures++;
                    $display("FAIL ovw_px idx=%0d got=%h exp=%h",
                             idx, obsVec, expVec(idx));
                end
                if (idx == 3 * W + 5) begin
                    checks++;
                    if (oData !== 1'b0) begin
                        failures++;
                        $display("FAIL ovw_53 got=%b exp=0", oData);
                    end
                end
                idx++;
            end
        end
        checks++;
        if (idx != N) begin
            failures++;
            $display("FAIL ovw_total got=%0d exp=%0d", idx, N);
        end
    endtask

    task automatic test_ignored_writes();
        int idx;
        do_reset();
        write_frame(1'b1, 1'b0);
        iReady    = 1'b1;
        iFinished = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < N + 20 && !oDone; cyc++) begin
            @(negedge clock);
            iFinished   = 1'b0;
            iResultWren = bit'($urandom % 2);
            iResultCol  = WB'($urandom);
            iResultRow  = HB'($urandom);
            iResultData = bit'($urandom % 2);
            if (oValid) begin
                checks++;
                if (obsVec !== expVec(idx)) begin
                    failures++;
                    $display("FAIL ign_px idx=%0d got=%h exp=%h",
                             idx, obsVec, expVec(idx));
                end
                idx++;
            end
        end
        checks++;
        if (idx != N || oWriteCount !== (WB+HB+1)'(N)) begin
            failures++;
            $display("FAIL ign_ro got=%0d/%0d exp=%0d/%0d",
                     idx, oWriteCount, N, N);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            iResultWren = 1'b1;
            iResultCol  = WB'($urandom);
            iResultRow  = HB'($urandom);
            iResultData = bit'($urandom % 2);
            iFinished   = bit'($urandom % 2);
            iReady      = bit'($urandom % 2);
            checks++;
            if ({oDone, oValid} !== 2'b10 || oWriteCount !== (WB+HB+1)'(N)) begin
                failures++;
                $display("FAIL ign_done got=%b/%0d exp=10/%0d",
                         {oDone, oValid}, oWriteCount, N);
            end
        end
        // Buffer survives reset: replay without writing shows it untouched.
        do_reset();
        iReady    = 1'b1;
        iFinished = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < N + 20 && !oDone; cyc++) begin
            @(negedge clock);
            iFinished = 1'b0;
            if (oValid) begin
                checks++;
                if (obsVec !== expVec(idx)) begin
                    failures++;
                    $display("FAIL ign_replay idx=%0d got=%h exp=%h",
                             idx, obsVec, expVec(idx));
                end
                idx++;
            end
        end
        checks++;
        if (idx != N || oWriteCount !== '0) begin
            failures++;
            $display("FAIL ign_replay_total got=%0d/%0d exp=%0d/0",
                     idx, oWriteCount, N);
        end
    endtask

    task automatic test_reset_midstream();
        int xfer;
        int idx;
        do_reset();
        write_frame(1'b0, 1'b0);
        iReady    = 1'b1;
        iFinished = 1'b1;
        xfer = 0;
        for (int cyc = 0; cyc < N && xfer < 100; cyc++) begin
            @(negedge clock);
            iFinished = 1'b0;
            if (oValid)
                xfer++;
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({oValid, oFirst, oLast, oDone, oData, oCol, oRow} !== '0
            || oWriteCount !== '0) begin
            failures++;
            $display("FAIL mid_reset xfer=%0d got=%b/%h/%0d exp=0",
                     xfer, {oValid, oFirst, oLast, oDone, oData},
                     {oCol, oRow}, oWriteCount);
        end
        @(negedge clock);
        reset   = 1'b0;
        nWrites = 0;
        write_frame(1'b1, 1'b0);
        iFinished = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < N + 20 && !oDone; cyc++) begin
            @(negedge clock);
            iFinished = 1'b0;
            if (oValid) begin
                checks++;
                if (obsVec !== expVec(idx)) begin
                    failures++;
                    $display("FAIL mid_px idx=%0d got=%h exp=%h",
                             idx, obsVec, expVec(idx));
                end
                idx++;
            end
        end
        checks++;
        if (idx != N || !oDone) begin
            failures++;
            $display("FAIL mid_total got=%0d done=%b exp=%0d", idx, oDone, N);
        end
    endtask

    initial begin
        reset       = 1'b1;
        iResultCol  = '0;
        iResultRow  = '0;
        iResultData = 1'b0;
        iResultWren = 1'b0;
        iFinished   = 1'b0;
        iReady      = 1'b0;
        nWrites     = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_overwrite();
        test_ignored_writes();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
